// File: rtl/wm_phase_sequencer_if.sv
// ---------------------------------------------------------------------------
// wm_phase_sequencer_if
// Signal bundle between the washing-machine main controller and the phase
// sequencer.
//
// Controller -> sequencer (requests and sensors):
//   sig_Start        request to begin a cycle
//   sig_Cancel       abort request / fault clear
//   sig_Lid_Closed   lid sensor
//   sig_Full         drum full sensor
//   sig_Temperature  target temperature reached
//   sig_Empty        drum empty sensor
// Sequencer -> controller (actuators and status):
//   valve_on, heater_on, motor_on, drain_on, lid_lock   actuator enables
//   phase            current state encoding (3 bits)
//   sig_Time_Out     sticky phase-timeout flag
//   sig_Completed    one-cycle pulse at normal cycle end
//
// Modports: master = main controller side, slave = phase sequencer side.
// ---------------------------------------------------------------------------
interface wm_phase_sequencer_if;
    logic       sig_Start;
    logic       sig_Cancel;
    logic       sig_Lid_Closed;
    logic       sig_Full;
    logic       sig_Temperature;
    logic       sig_Empty;

    logic       valve_on;
    logic       heater_on;
    logic       motor_on;
    logic       drain_on;
    logic       lid_lock;
    logic [2:0] phase;
    logic       sig_Time_Out;
    logic       sig_Completed;

    modport master (
        output sig_Start, sig_Cancel, sig_Lid_Closed,
               sig_Full, sig_Temperature, sig_Empty,
        input  valve_on, heater_on, motor_on, drain_on, lid_lock,
               phase, sig_Time_Out, sig_Completed
    );

    modport slave (
        input  sig_Start, sig_Cancel, sig_Lid_Closed,
               sig_Full, sig_Temperature, sig_Empty,
        output valve_on, heater_on, motor_on, drain_on, lid_lock,
               phase, sig_Time_Out, sig_Completed
    );
endinterface

// File: rtl/wm_phase_sequencer.sv
// ---------------------------------------------------------------------------
// wm_phase_sequencer
// Drives valve, heater, drum motor and drain pump through the fill, heat,
// wash, drain and spin phases of a granted washing cycle, times each phase,
// and reports phase timeouts and normal cycle completion.
//
// Ports:
//   clock   in   single clock, rising edge
//   reset   in   asynchronous, active-high reset
//   seq     wm_phase_sequencer_if.slave  sensors/requests in, actuators and
//                status out (see the interface file)
//
// Build option:
//   WM_HEAT_EN  defined   -> HEAT phase between FILL and WASH.
//               undefined -> FILL goes straight to WASH, heater tied off,
//                            sig_Temperature ignored; other encodings kept.
//
// State table:
//   state | phase | meaning
//   IDLE  |   0   | waiting for start with lid closed
//   FILL  |   1   | water valve open until drum full
//   HEAT  |   2   | heater on until target temperature
//   WASH  |   3   | drum turns for a fixed time
//   DRAIN |   4   | pump runs until drum empty
//   SPIN  |   5   | drum and pump for a fixed time
//   DONE  |   6   | single-cycle completion pulse
//   FAULT |   7   | lid opened or phase timed out; wait for cancel
// ---------------------------------------------------------------------------
module wm_phase_sequencer #(
    parameter int CNT_W         = 8,
    parameter int FILL_TIMEOUT  = 64,
    parameter int HEAT_TIMEOUT  = 128,
    parameter int WASH_TICKS    = 200,
    parameter int DRAIN_TIMEOUT = 64,
    parameter int SPIN_TICKS    = 150
) (
    input  logic                 clock,
    input  logic                 reset,
    wm_phase_sequencer_if.slave  seq
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_HEAT  = 3'd2;
    localparam logic [2:0] S_WASH  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_SPIN  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_FAULT = 3'd7;

    // Terminal timer values: the timer reads LIMIT-1 in the last allowed
    // cycle of a phase, so a phase lasts at most LIMIT cycles.
    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WASH_LAST  = CNT_W'(WASH_TICKS - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SPIN_LAST  = CNT_W'(SPIN_TICKS - 1);
`ifdef WM_HEAT_EN
    localparam logic [CNT_W-1:0] HEAT_LAST  = CNT_W'(HEAT_TIMEOUT - 1);
`endif

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] timer;
    logic             aborted;
    logic             time_out;
    logic             timeout_hit;
    logic             abort_set;

`ifndef WM_HEAT_EN
    // Temperature sensor has no consumer without the HEAT phase.
    logic heat_unused;
    assign heat_unused = seq.sig_Temperature;
`endif

    // Next-state logic. Priority inside each active phase:
    // lid open > cancel > sensor > timer.
    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        abort_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (seq.sig_Start && seq.sig_Lid_Closed)
                    state_nxt = S_FILL;
            end
            S_FILL: begin
                if (!seq.sig_Lid_Closed) begin
                    state_nxt = S_FAULT;
                end else if (seq.sig_Cancel) begin
                    state_nxt = S_DRAIN;
                    abort_set = 1'b1;
                end else if (seq.sig_Full) begin
`ifdef WM_HEAT_EN
                    state_nxt = S_HEAT;
`else
                    state_nxt = S_WASH;
`endif
                end else if (timer == FILL_LAST) begin
                    state_nxt   = S_FAULT;
                    timeout_hit = 1'b1;
                end
            end
`ifdef WM_HEAT_EN
            S_HEAT: begin
                if (!seq.sig_Lid_Closed) begin
                    state_nxt = S_FAULT;
                end else if (seq.sig_Cancel) begin
                    state_nxt = S_DRAIN;
                    abort_set = 1'b1;
                end else if (seq.sig_Temperature) begin
                    state_nxt = S_WASH;
                end else if (timer == HEAT_LAST) begin
                    state_nxt   = S_FAULT;
                    timeout_hit = 1'b1;
                end
            end
`else
            // Unreachable without heating; recover to IDLE if ever seen.
            S_HEAT: state_nxt = S_IDLE;
`endif
            S_WASH: begin
                if (!seq.sig_Lid_Closed) begin
                    state_nxt = S_FAULT;
                end else if (seq.sig_Cancel) begin
                    state_nxt = S_DRAIN;
                    abort_set = 1'b1;
                end else if (timer == WASH_LAST) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Cancel is deliberately ignored: water must leave first.
                if (!seq.sig_Lid_Closed) begin
                    state_nxt = S_FAULT;
                end else if (seq.sig_Empty) begin
                    state_nxt = aborted ? S_IDLE : S_SPIN;
                end else if (timer == DRAIN_LAST) begin
                    state_nxt   = S_FAULT;
                    timeout_hit = 1'b1;
                end
            end
            S_SPIN: begin
                if (!seq.sig_Lid_Closed)
                    state_nxt = S_FAULT;
                else if (seq.sig_Cancel)
                    state_nxt = S_IDLE;
                else if (timer == SPIN_LAST)
                    state_nxt = S_DONE;
            end
            S_DONE: state_nxt = S_IDLE;
            S_FAULT: begin
                if (seq.sig_Cancel)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            timer    <= '0;
            aborted  <= 1'b0;
            time_out <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state_nxt != state)
                timer <= '0;
            else
                timer <= timer + 1'b1;

            if (state_nxt == S_IDLE)
                aborted <= 1'b0;
            else if (abort_set)
                aborted <= 1'b1;

            if (timeout_hit)
                time_out <= 1'b1;
            else if (state == S_FAULT && state_nxt == S_IDLE)
                time_out <= 1'b0;
        end
    end

    // Moore outputs straight off the state register, so an asynchronous
    // reset drops every actuator without waiting for a clock edge.
    assign seq.valve_on      = (state == S_FILL);
`ifdef WM_HEAT_EN
    assign seq.heater_on     = (state == S_HEAT);
`else
    assign seq.heater_on     = 1'b0;
`endif
    assign seq.motor_on      = (state == S_WASH) || (state == S_SPIN);
    assign seq.drain_on      = (state == S_DRAIN) || (state == S_SPIN);
    assign seq.lid_lock      = (state >= S_FILL) && (state <= S_SPIN);
    assign seq.phase         = state;
    assign seq.sig_Time_Out  = time_out;
    assign seq.sig_Completed = (state == S_DONE);

endmodule

// File: doc/wm_phase_sequencer.md
# wm_phase_sequencer

Phase sequencer for the washing-machine controller. Once the main controller grants a paid, lid-closed cycle, this block drives the water valve, heater, drum motor and drain pump through the fill, heat, wash, drain and spin phases. It times each phase and produces the `sig_Time_Out` and `sig_Completed` indications that the main controller consumes.

## Interface
- `CNT_W`, 8: phase timer width; every limit below must be ≤ 2^CNT_W.
- `FILL_TIMEOUT`, 64: maximum FILL duration in cycles.
- `HEAT_TIMEOUT`, 128: maximum HEAT duration in cycles.
- `WASH_TICKS`, 200: exact WASH duration in cycles.
- `DRAIN_TIMEOUT`, 64: maximum DRAIN duration in cycles.
- `SPIN_TICKS`, 150: exact SPIN duration in cycles.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sig_Start`  in  1  request to begin a cycle; sampled in IDLE only.
- `sig_Cancel`  in  1  abort request, or fault clear.
- `sig_Lid_Closed`  in  1  lid sensor.
- `sig_Full`  in  1  drum full sensor.
- `sig_Temperature`  in  1  target temperature reached.
- `sig_Empty`  in  1  drum empty sensor.
- `valve_on`, `heater_on`, `motor_on`, `drain_on`, `lid_lock`  out  1 each  actuator enables.
- `phase`  out  3  current state encoding.
- `sig_Time_Out`  out  1  sticky phase-timeout flag.
- `sig_Completed`  out  1  one-cycle pulse at normal cycle end.

## Operation
- States and `phase` encoding: IDLE=0, FILL=1, HEAT=2, WASH=3, DRAIN=4, SPIN=5, DONE=6, FAULT=7.
- Outputs are Moore-decoded from the state register:
  - `valve_on` in FILL.
  - `heater_on` in HEAT.
  - `motor_on` in WASH and SPIN.
  - `drain_on` in DRAIN and SPIN.
  - `lid_lock` in FILL through SPIN.
  - `sig_Completed` in DONE.
- Phase timer: CNT_W-bit counter, cleared on every state change, otherwise incremented each cycle.
- Transitions, evaluated every edge. Priority: lid open > cancel > sensor > timer.
  - IDLE: `sig_Start` && `sig_Lid_Closed` → FILL. A start with the lid open is ignored.
  - FILL: `sig_Full` → HEAT; else timer == FILL_TIMEOUT−1 → FAULT.
  - HEAT: `sig_Temperature` → WASH; else timer == HEAT_TIMEOUT−1 → FAULT.
  - WASH: timer == WASH_TICKS−1 → DRAIN.
  - DRAIN: `sig_Empty` → SPIN (normal) or IDLE (aborted); else timer == DRAIN_TIMEOUT−1 → FAULT.
  - SPIN: timer == SPIN_TICKS−1 → DONE.
  - DONE: → IDLE unconditionally.
  - FAULT: holds until `sig_Cancel` → IDLE.
- Abort behaviour:
  - `sig_Cancel` in FILL, HEAT or WASH → DRAIN and sets an internal `aborted` flag, so water is always drained before the lid unlocks.
  - In DRAIN, cancel is ignored.
  - In SPIN, cancel → IDLE.
  - The `aborted` flag clears on entry to IDLE.
- `sig_Lid_Closed`=0 in any of FILL through SPIN → FAULT, regardless of cancel.
- `sig_Time_Out`:
  - Set on any timeout-driven entry to FAULT.
  - Cleared on the FAULT→IDLE exit.
  - A lid-open fault does not set it.
- `sig_Completed` is never asserted after an aborted cycle.

## Timing
- Reset value of every output is 0, with `phase`=0. Reset also clears the state, timer and `aborted` flag.
- Reset asserted mid-cycle forces all actuators off immediately, without waiting for a clock edge.
- Latency from start: `sig_Start` sampled high at edge k → `phase`=1 and `valve_on`=1 after edge k.
- Sensors have one-cycle latency: a sensor sampled high at edge k changes the state at edge k.
- Fixed phases (WASH, SPIN) occupy exactly WASH_TICKS and SPIN_TICKS cycles.
- Timeout phases occupy at most their limit in cycles.
- Sensor and timeout true in the same cycle: the sensor wins, with no fault.
- `sig_Completed` is high for exactly one cycle, and IDLE follows.
- `sig_Start` held high across DONE→IDLE starts a new cycle at the next edge if the lid is closed.

## Configuration
- `WM_HEAT_EN` defined:
  - HEAT state present as described.
- `WM_HEAT_EN` undefined:
  - FILL exits on `sig_Full` directly to WASH.
  - `heater_on` is tied to 0.
  - `sig_Temperature` is ignored.
  - `phase` never equals 2.
  - Encodings of all other states are unchanged.

## Test plan
Bench parameters: FILL_TIMEOUT=8, HEAT_TIMEOUT=8, WASH_TICKS=5, DRAIN_TIMEOUT=8, SPIN_TICKS=4.
- Normal cycle:
  - Stimulus: lid closed, start pulse; `sig_Full` after 3 cycles, `sig_Temperature` after 2, `sig_Empty` after 2.
  - Response: `phase` sequence 1,2,3,4,5,6,0; WASH lasts 5 cycles, SPIN 4; `sig_Completed` high one cycle; `sig_Time_Out`=0.
- Fill timeout:
  - Stimulus: start with `sig_Full` never asserted.
  - Response: FAULT after exactly 8 FILL cycles; `sig_Time_Out`=1; all actuators 0.
  - Follow-up: `sig_Cancel` → IDLE, `sig_Time_Out`=0.
- Cancel during WASH:
  - Response: DRAIN next cycle; then `sig_Empty` → IDLE with no SPIN and no `sig_Completed`.
- Lid open during SPIN:
  - Response: FAULT next cycle; `sig_Time_Out`=0; `motor_on`=0.
- Edge cases:
  - `sig_Full` asserted in the last FILL cycle (timer=7) → HEAT, not FAULT.
  - Start with lid open → stays IDLE.
- Async reset asserted mid-WASH:
  - Response: all outputs 0 before the next edge.
  - After reset release: IDLE.
  - Repeat the normal-cycle scenario with `WM_HEAT_EN` undefined: `phase` sequence 1,3,4,5,6,0.
